ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the shooting-game core. It takes the raw ps2_clk/ps2_data pad inputs and synchronizes them into the board clock domain. It deframes 11-bit device-to-host frames and delivers one decoded key event per make/break sequence. E0 (extended) and F0 (break) prefix bytes are absorbed, and a watchdog recovers from partial frames.

Parameters:
TIMEOUT_CYCLES, 25000, board_clk cycles without a ps2_clk falling edge before a mid-frame abort (1 ms at 25 MHz)
TO_W, 15, width of the watchdog counter; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
board_clk  input  1  system clock; all logic in this single domain
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pad, asynchronous
ps2_data  input  1  raw PS/2 data pad, asynchronous
code  output  8  scan code of the last event; held until the next event
code_valid  output  1  single-cycle strobe; code/code_ext/code_break valid in this cycle
code_ext  output  1  event was E0-prefixed
code_break  output  1  event was F0-prefixed (key release)
frame_err  output  1  single-cycle strobe on bad start, parity, stop, or timeout
busy  output  1  high while the FSM is outside IDLE
key_left  output  1  held state of E0 6B (see Optional Feature)
key_right  output  1  held state of E0 74
key_fire  output  1  held state of 29 (space)

Behaviour:
- Reset: all outputs 0; FSM = IDLE; prefix flags, shift register and watchdog cleared. Synchronizer flops reset to 1 (bus idle-high).
- Synchronization: 2-flop synchronizer on each pad, plus a previous-value register on ps2_clk.
- Edge detect: a falling edge is flagged when prev=1 and sync=0. All sampling happens only on this edge.
- Latency: code_valid rises on the 4th board_clk edge after the stop-bit falling edge at the pin: 2 sync cycles, 1 detect cycle, 1 registered output cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, data=0 goes to DATA with bit count 0. data=1 pulses frame_err and stays in IDLE.
  - DATA: on each edge, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit. Odd parity is required: XOR of the 8 data bits and the parity bit must equal 1. Go to STOP.
  - STOP: on an edge, go to IDLE. If data=1 and parity is good, the frame is accepted. Otherwise pulse frame_err and drop the byte.
- Accepted byte handling:
  - E0: set ext_flag; no event emitted.
  - F0: set brk_flag; no event emitted.
  - Any other byte: drive code=byte, code_ext=ext_flag, code_break=brk_flag, pulse code_valid, then clear both flags.
- frame_err clears both prefix flags, so an orphan prefix cannot corrupt a later event.
- Watchdog:
  - Counts board_clk cycles while FSM≠IDLE and resets to 0 on every detected edge.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, clear the shift register and prefix flags.
  - Held at 0 in IDLE.
- Simultaneous events: watchdog expiry and an edge in the same cycle → the edge wins and the counter resets.
- code_valid and frame_err are never high in the same cycle.
- Host-to-device inhibit is not supported; the block is receive-only.
- busy = (state≠IDLE).
- Reset asserted mid-frame aborts immediately. No strobe is emitted during or after reset.

Optional Feature:
- Macro: PS2_KEY_STATE_EN.
- Defined: on each code_valid, the held flags update.
  - E0 6B sets key_left; the same with code_break clears it.
  - E0 74 sets and clears key_right the same way.
  - Non-extended 29 sets and clears key_fire the same way.
  - Other codes leave the flags unchanged.
  - Flags update in the same cycle as code_valid, visible the cycle after.
  - frame_err does not change them. Reset clears them.
- Not defined: key_left/key_right/key_fire are tied to 0 and no tracking logic is built.

Test Plan:
- Frame 0x1C with parity bit 0 and stop 1 → exactly one code_valid, code=0x1C, code_ext=0, code_break=0, frame_err stays 0, busy falls after the stop bit.
- Frames F0, 1C → one code_valid only, code=0x1C, code_break=1, code_ext=0.
- Frames E0, F0, 74 → one code_valid, code=0x74, code_ext=1, code_break=1. A following 0x1C frame gives code_ext=0, code_break=0.
- Frame 0x1C with parity bit 1 → one frame_err pulse, no code_valid. A following F0, 1C still reports code_break=1 only if F0 arrived after the error.
- Five clock pulses then silence → frame_err after TIMEOUT_CYCLES cycles, busy=0. A following valid 0x29 frame decodes correctly.
- With PS2_KEY_STATE_EN: E0 6B → key_left=1; 29 → key_fire=1; E0 F0 6B → key_left=0 while key_fire stays 1; assert reset → all 0. Without the macro the same stimulus leaves all three at 0.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver for the shooting-game core.
//   Brings the raw ps2_clk/ps2_data pads into the board_clk domain and
//   deframes 11-bit device-to-host frames (start, 8 data LSB first, odd
//   parity, stop). E0 (extended) and F0 (break) prefix bytes are folded into
//   the event that follows them. A watchdog aborts frames that stall.
//
// Parameters:
//   TIMEOUT_CYCLES  board_clk cycles without a ps2_clk fall before mid-frame abort
//   TO_W            watchdog counter width, 2**TO_W > TIMEOUT_CYCLES
//
// Ports:
//   board_clk, reset        clock / async active-high reset
//   ps2_clk, ps2_data       raw asynchronous pads
//   code[7:0]               scan code of the last event (held)
//   code_valid              1-cycle strobe, code/code_ext/code_break valid
//   code_ext, code_break    event was E0 / F0 prefixed
//   frame_err               1-cycle strobe: bad start, parity, stop, timeout
//   busy                    FSM outside IDLE
//   key_left/right/fire     held key states (E0 6B, E0 74, 29)
//
// Optional feature: define PS2_KEY_STATE_EN to build the held key-state
// tracking; otherwise key_* are tied to 0.
module ps2_kbd_rx #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int TO_W           = 15
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_ext,
  output logic       code_break,
  output logic       frame_err,
  output logic       busy,
  output logic       key_left,
  output logic       key_right,
  output logic       key_fire
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronizers reset to 1 so a bus that idles high never looks like an edge.
  logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic fall_d, data_d;  // registered edge strobe and the data bit sampled with it

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      fall_d   <= 1'b0;
      data_d   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      fall_d   <= clk_prev & ~clk_s2;
      data_d   <= data_s2;
    end
  end

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              par_bit, par_bit_n;
  logic [TO_W-1:0]   wd_cnt, wd_cnt_n;
  logic              ext_flag, ext_flag_n, brk_flag, brk_flag_n;
  logic [7:0]        code_n;
  logic              code_valid_n, code_ext_n, code_break_n, frame_err_n;
  logic              timeout;

  // An edge in the expiry cycle wins, so timeout is masked by fall_d.
  assign timeout = (state != IDLE) && !fall_d &&
                   (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    ext_flag_n   = ext_flag;
    brk_flag_n   = brk_flag;
    code_n       = code;
    code_ext_n   = code_ext;
    code_break_n = code_break;
    code_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    wd_cnt_n     = (state == IDLE || fall_d) ? '0 : wd_cnt + 1'b1;

    if (timeout) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      shreg_n     = '0;
      ext_flag_n  = 1'b0;
      brk_flag_n  = 1'b0;
      frame_err_n = 1'b1;
      wd_cnt_n    = '0;
    end else if (fall_d) begin
      unique case (state)
        IDLE: begin
          if (!data_d) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            frame_err_n = 1'b1;
            ext_flag_n  = 1'b0;
            brk_flag_n  = 1'b0;
          end
        end
        DATA: begin
          shreg_n   = {data_d, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = data_d;
          state_n   = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_d && ((^shreg) ^ par_bit)) begin
            if (shreg == 8'hE0) begin
              ext_flag_n = 1'b1;
            end else if (shreg == 8'hF0) begin
              brk_flag_n = 1'b1;
            end else begin
              code_n       = shreg;
              code_ext_n   = ext_flag;
              code_break_n = brk_flag;
              code_valid_n = 1'b1;
              ext_flag_n   = 1'b0;
              brk_flag_n   = 1'b0;
            end
          end else begin
            frame_err_n = 1'b1;
            ext_flag_n  = 1'b0;
            brk_flag_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      wd_cnt     <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      code_ext   <= 1'b0;
      code_break <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      wd_cnt     <= wd_cnt_n;
      ext_flag   <= ext_flag_n;
      brk_flag   <= brk_flag_n;
      code       <= code_n;
      code_valid <= code_valid_n;
      code_ext   <= code_ext_n;
      code_break <= code_break_n;
      frame_err  <= frame_err_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef PS2_KEY_STATE_EN
  // Held key states follow the event strobe; a break clears, a make sets.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_fire  <= 1'b0;
    end else if (code_valid) begin
      if (code_ext  && code == 8'h6B) key_left  <= !code_break;
      if (code_ext  && code == 8'h74) key_right <= !code_break;
      if (!code_ext && code == 8'h29) key_fire  <= !code_break;
    end
  end
`else
  assign key_left  = 1'b0;
  assign key_right = 1'b0;
  assign key_fire  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: self-checking bench for ps2_kbd_rx. Frames are driven at the
// pad level; a reference model applies the prefix/event rules to each byte
// sent and the observed strobes are compared against its expected stream.
module tb_ps2_kbd_rx;
  localparam int TO   = 300;
  localparam int HALF = 20;
`ifdef PS2_KEY_STATE_EN
  localparam bit KEYS = 1'b1;
`else
  localparam bit KEYS = 1'b0;
`endif

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic       board_clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, code_ext, code_break, frame_err, busy;
  logic       key_left, key_right, key_fire;

  ps2_kbd_rx #(.TIMEOUT_CYCLES(TO), .TO_W(9)) dut (
    .board_clk(board_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .code_ext(code_ext),
    .code_break(code_break), .frame_err(frame_err), .busy(busy),
    .key_left(key_left), .key_right(key_right), .key_fire(key_fire));

  always #5 board_clk = ~board_clk;

  int  tests = 0, fails = 0;
  int  cyc = 0, fall_cyc = 0, valid_cyc = 0;
  bit  both_seen = 1'b0;
  ev_t obs[$], exp_q[$];
  bit  m_ext, m_brk, m_left, m_right, m_fire;

  always @(posedge board_clk) cyc <= cyc + 1;

  always @(posedge board_clk) begin
    #1;
    if (code_valid) begin
      obs.push_back('{1'b0, code, code_ext, code_break});
      valid_cyc = cyc;
    end
    if (frame_err) obs.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    if (code_valid && frame_err) both_seen = 1'b1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  // Reference: prefixes accumulate, any other good byte is one event,
  // any bad frame is an error that forgets pending prefixes.
  task automatic model_apply(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      exp_q.push_back('{1'b0, b, m_ext, m_brk});
      if (m_ext && b == 8'h6B) m_left = !m_brk;
      if (m_ext && b == 8'h74) m_right = !m_brk;
      if (!m_ext && b == 8'h29) m_fire = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input bit d);
    @(negedge board_clk) ps2_data = d;
    wait_cyc(HALF / 2);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  // mode 0: good, 1: bad parity, 2: bad stop
  task automatic send_frame(input logic [7:0] b, input int mode);
    bit p;
    p = ~(^b);
    if (mode == 1) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(mode == 2 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    model_apply(b, mode == 0);
    wait_cyc(10);
  endtask

  task automatic check_events(input string name);
    wait_cyc(8);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s count: got %0d events, expected %0d", name, obs.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs.size(); i++) begin
        tests++;
        if (obs[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s ev%0d: got err=%b code=%h ext=%b brk=%b, expected err=%b code=%h ext=%b brk=%b",
                   name, i, obs[i].err, obs[i].code, obs[i].ext, obs[i].brk,
                   exp_q[i].err, exp_q[i].code, exp_q[i].ext, exp_q[i].brk);
        end
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic check_keys(input string name);
    logic [2:0] e;
    e = KEYS ? {m_left, m_right, m_fire} : 3'b000;
    tests++;
    if ({key_left, key_right, key_fire} !== e) begin
      fails++;
      $display("FAIL %s keys: got %b expected %b", name, {key_left, key_right, key_fire}, e);
    end
  endtask

  task automatic check_busy(input string name, input logic e);
    tests++;
    if (busy !== e) begin
      fails++;
      $display("FAIL %s busy: got %b expected %b", name, busy, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(4);
    m_ext = 0; m_brk = 0; m_left = 0; m_right = 0; m_fire = 0;
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({code, code_valid, code_ext, code_break, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset outputs: got %h expected 000", {code, code_valid, code_ext, code_break, frame_err});
    end
    check_busy("reset", 1'b0);
    check_keys("reset");
    reset = 1'b0;
    wait_cyc(4);
    // partial frame then reset: must abort with no strobe
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    check_busy("midframe", 1'b1);
    reset = 1'b1;
    wait_cyc(2);
    check_busy("midframe_rst", 1'b0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(4);
    check_events("midframe_rst");
    send_frame(8'h1C, 0);
    check_events("after_rst");
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 0);
    tests++;
    if (valid_cyc - fall_cyc != 4) begin
      fails++;
      $display("FAIL latency: got %0d expected 4", valid_cyc - fall_cyc);
    end
    check_busy("basic_end", 1'b0);
    check_events("basic");
  endtask

  task automatic test_prefixes();
    send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    check_events("break");
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h74, 0); send_frame(8'h1C, 0);
    check_events("ext_break");
  endtask

  task automatic test_errors();
    send_frame(8'h1C, 1); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    check_events("parity");
    send_frame(8'hF0, 0); send_frame(8'h1C, 2); send_frame(8'h1C, 0);
    check_events("stop");
    send_frame(8'hE0, 0);
    ps2_bit(1'b1);  // start bit high
    ps2_data = 1'b1;
    model_apply(8'h00, 1'b0);
    wait_cyc(10);
    send_frame(8'h1C, 0);
    check_events("bad_start");
  endtask

  task automatic test_timeout();
    int  cnt;
    bit  seen;
    send_frame(8'hE0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    @(negedge board_clk) ps2_data = 1'b1;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    cnt = 0; seen = 0;
    while (!seen && cnt < TO + 40) begin
      @(negedge board_clk);
      cnt++;
      if (cnt == HALF) ps2_clk = 1'b1;
      if (cnt == TO / 2) check_busy("to_wait", 1'b1);
      if (frame_err) seen = 1;
    end
    tests++;
    if (!seen || cnt < TO || cnt > TO + 8) begin
      fails++;
      $display("FAIL timeout: frame_err at cycle %0d (seen=%b), expected %0d..%0d", cnt, seen, TO, TO + 8);
    end
    check_busy("to_after", 1'b0);
    model_apply(8'h00, 1'b0);
    send_frame(8'h29, 0);
    check_events("timeout");
  endtask

  task automatic test_keys();
    do_reset();
    reset = 1'b0;
    wait_cyc(4);
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    check_events("keys_left"); check_keys("left_set");
    send_frame(8'h29, 0);
    check_events("keys_fire"); check_keys("fire_set");
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0);
    check_events("keys_rel"); check_keys("left_clr");
    send_frame(8'hE0, 0); send_frame(8'h74, 0); send_frame(8'h29, 1);
    check_events("keys_err"); check_keys("right_err");
    do_reset();
    check_keys("keys_rst");
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r, mode;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h6B;
        3: b = 8'h74;
        4: b = 8'h29;
        default: b = 8'($urandom);
      endcase
      r = $urandom_range(0, 11);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      send_frame(b, mode);
    end
    check_events("random");
    check_keys("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefixes();
    test_errors();
    test_timeout();
    test_keys();
    test_random();
    tests++;
    if (both_seen) begin
      fails++;
      $display("FAIL exclusive: code_valid and frame_err high together, got 1 expected 0");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "time limit");
  end
endmodule
